// File: rtl/sdcmd_device.sv
// SD command-line device endpoint: receives 48-bit host command frames on
// sdcmd, hands them to the user, and optionally transmits a 48-bit response
// after an Ncr gap. sdclk and sdcmd are sampled as asynchronous data on clk.
module sdcmd_device #(
    parameter int NCR = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sdclk,
    inout  wire         sdcmd,
    output logic        cmd_valid,
    output logic [5:0]  cmd_idx,
    output logic [31:0] cmd_arg,
    output logic        cmd_crcok,
    output logic        cmd_endok,
    input  logic        resp_start,
    input  logic        resp_none,
    input  logic [5:0]  resp_idx,
    input  logic [31:0] resp_arg,
    output logic        busy,
    output logic        resp_done
);

    typedef enum logic [2:0] {S_IDLE, S_RX, S_WAIT, S_NCR, S_TX} state_e;

    state_e      state_q, state_d;
    logic        sclk_s1_q, sclk_s2_q, sclk_d_q;
    logic        cmd_s1_q, cmd_s2_q;
    logic [5:0]  bitcnt_q;
    logic [45:0] sh_q;
    logic [6:0]  crc_q;
    logic [6:0]  fallcnt_q;
    logic [39:0] txsh_q;
    logic        oe_q, dout_q;
    logic        cmd_valid_q, resp_done_q;
    logic [5:0]  cmd_idx_q;
    logic [31:0] cmd_arg_q;
    logic        cmd_crcok_q, cmd_endok_q;
    logic        rise, fall, ncr_met;

    // Serial CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    assign rise    = sclk_s2_q & ~sclk_d_q;
    assign fall    = ~sclk_s2_q & sclk_d_q;
    assign ncr_met = (fallcnt_q >= 7'(NCR - 1));

    // Line is driven straight from registers; reset clears oe_q asynchronously.
    assign sdcmd = oe_q ? dout_q : 1'bz;

    // Synchronizers idle high, matching an idle line and a high sdclk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_s1_q <= 1'b1;
            sclk_s2_q <= 1'b1;
            sclk_d_q  <= 1'b1;
            cmd_s1_q  <= 1'b1;
            cmd_s2_q  <= 1'b1;
        end else begin
            sclk_s1_q <= sdclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_d_q  <= sclk_s2_q;
            cmd_s1_q  <= sdcmd;
            cmd_s2_q  <= cmd_s1_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; resp_none has priority over resp_start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rise && !cmd_s2_q) state_d = S_RX;
            S_RX:   if (rise && bitcnt_q == 6'd47) state_d = sh_q[45] ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (resp_none)                         state_d = S_IDLE;
                else if (resp_start)                   state_d = S_NCR;
                else if (fall && fallcnt_q == 7'd63)   state_d = S_IDLE;
            end
            S_NCR:  if (fall && ncr_met) state_d = S_TX;
            S_TX:   if (fall && bitcnt_q == 6'd48) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs derived from state and registers only.
    always_comb begin
        busy      = (state_q != S_IDLE);
        cmd_valid = cmd_valid_q;
        resp_done = resp_done_q;
        cmd_idx   = cmd_idx_q;
        cmd_arg   = cmd_arg_q;
        cmd_crcok = cmd_crcok_q;
        cmd_endok = cmd_endok_q;
    end

    // Receive shifting, CRC, fall counting and response serialization.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bitcnt_q    <= '0;
            sh_q        <= '0;
            crc_q       <= '0;
            fallcnt_q   <= '0;
            txsh_q      <= '0;
            oe_q        <= 1'b0;
            dout_q      <= 1'b1;
            cmd_valid_q <= 1'b0;
            resp_done_q <= 1'b0;
            cmd_idx_q   <= '0;
            cmd_arg_q   <= '0;
            cmd_crcok_q <= 1'b0;
            cmd_endok_q <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            resp_done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (rise && !cmd_s2_q) begin
                    // Start bit is a zero, so the CRC stays at its zero init.
                    bitcnt_q <= 6'd1;
                    sh_q     <= '0;
                    crc_q    <= '0;
                end
                S_RX: if (rise) begin
                    sh_q     <= {sh_q[44:0], cmd_s2_q};
                    bitcnt_q <= bitcnt_q + 6'd1;
                    if (bitcnt_q < 6'd40) crc_q <= crc7_step(crc_q, cmd_s2_q);
                    if (bitcnt_q == 6'd47) begin
                        // sh_q holds bits 1..46, cmd_s2_q is the end bit.
                        fallcnt_q <= '0;
                        if (sh_q[45]) begin
                            cmd_valid_q <= 1'b1;
                            cmd_idx_q   <= sh_q[44:39];
                            cmd_arg_q   <= sh_q[38:7];
                            cmd_crcok_q <= (sh_q[6:0] == crc_q);
                            cmd_endok_q <= cmd_s2_q;
                        end
                    end
                end
                S_WAIT: begin
                    if (fall && fallcnt_q != 7'h7f) fallcnt_q <= fallcnt_q + 7'd1;
                    if (resp_start && !resp_none) txsh_q <= {2'b00, resp_idx, resp_arg};
                end
                S_NCR: if (fall) begin
                    if (fallcnt_q != 7'h7f) fallcnt_q <= fallcnt_q + 7'd1;
                    if (ncr_met) begin
                        oe_q     <= 1'b1;
                        dout_q   <= txsh_q[39];
                        txsh_q   <= {txsh_q[38:0], 1'b0};
                        crc_q    <= crc7_step(7'd0, txsh_q[39]);
                        bitcnt_q <= 6'd1;
                    end
                end
                S_TX: if (fall) begin
                    if (bitcnt_q < 6'd40) begin
                        dout_q <= txsh_q[39];
                        txsh_q <= {txsh_q[38:0], 1'b0};
                        crc_q  <= crc7_step(crc_q, txsh_q[39]);
                    end else if (bitcnt_q < 6'd47) begin
                        dout_q <= crc_q[6];
                        crc_q  <= {crc_q[5:0], 1'b0};
                    end else if (bitcnt_q == 6'd47) begin
                        dout_q <= 1'b1;
                    end else begin
                        oe_q        <= 1'b0;
                        dout_q      <= 1'b1;
                        resp_done_q <= 1'b1;
                    end
                    if (bitcnt_q != 6'd48) bitcnt_q <= bitcnt_q + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sdcmd_device.md
SDCMD_DEVICE -- requirements
Module: sdcmd_device

Interface
REQ-001 Parameter NCR, default 2, is the number of complete sdclk cycles between the sampled command end bit and the driven response start bit (legal range 2..64).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1: system clock; all logic on posedge.
REQ-004 Port rstn, input, 1: asynchronous, active-low reset.
REQ-005 Port sdclk, input, 1: SD clock from the host; treated as asynchronous data.
REQ-006 Port sdcmd, inout, 1: SD command line; driven only during response transmit, otherwise Z (external pull-up).
REQ-007 Port cmd_valid, output, 1: one-clk pulse, command frame received.
REQ-008 Port cmd_idx, output, 6: received command index.
REQ-009 Port cmd_arg, output, 32: received argument.
REQ-010 Port cmd_crcok, output, 1: received CRC7 matched.
REQ-011 Port cmd_endok, output, 1: received end bit was 1.
REQ-012 Port resp_start, input, 1: user requests a response with resp_idx/resp_arg.
REQ-013 Port resp_none, input, 1: user declines to respond.
REQ-014 Port resp_idx, input, 6: response index field.
REQ-015 Port resp_arg, input, 32: response payload.
REQ-016 Port busy, output, 1: high from start-bit detection until return to IDLE.
REQ-017 Port resp_done, output, 1: one-clk pulse after the response end bit has been driven.

Function
REQ-018 sdclk and sdcmd SHALL each pass through a 2-FF synchronizer; rise/fall events are detected from the synchronized sdclk, delayed by one further FF.
REQ-019 Legal operation requires each sdclk phase to be at least 4 clk cycles; behaviour for shorter phases is undefined.
REQ-020 FSM states: IDLE, RX, WAIT_USER, NCR, TX.
REQ-021 IDLE -> RX occurs on an sdclk rise when synchronized sdcmd=0; busy SHALL assert that clk.
REQ-022 RX SHALL sample the 47 remaining bits MSB-first on successive sdclk rises.
REQ-023 CRC7 (x^7+x^3+1, init 0) SHALL cover the 40 bits from the start bit through arg[0].
REQ-024 If the transmission bit is 0, the frame SHALL be discarded (no cmd_valid) and the FSM SHALL return to IDLE after 48 bits.
REQ-025 After the end bit, cmd_valid SHALL pulse 1 clk later, with cmd_idx/cmd_arg/cmd_crcok/cmd_endok valid and held until the next cmd_valid; the FSM then enters WAIT_USER.
REQ-026 In WAIT_USER, resp_none -> IDLE without driving sdcmd.
REQ-027 In WAIT_USER, resp_start SHALL latch resp_idx/resp_arg and enter NCR.
REQ-028 If resp_start and resp_none are asserted together, resp_none wins.
REQ-029 In WAIT_USER, NCR and TX, sdclk rises SHALL NOT start a new RX.
REQ-030 NCR SHALL count sdclk falls from the end bit.
REQ-031 Sdcmd SHALL be driven on the first sdclk fall after NCR full cycles have elapsed and resp_start has been accepted.
REQ-032 If resp_start arrives late, driving SHALL begin on the next fall.
REQ-033 If WAIT_USER persists for 64 sdclk falls, the FSM SHALL return to IDLE silently.
REQ-034 TX SHALL drive 48 bits, one per sdclk fall, MSB-first, each held until the next fall: 0, 0, resp_idx, resp_arg, CRC7 over the first 40 bits, 1.
REQ-035 On the sdclk fall after the end bit, sdcmd SHALL be released to Z, resp_done SHALL pulse, and the FSM SHALL enter IDLE.
REQ-036 Sdcmd direction and data SHALL come from registers, never from combinational logic.

Reset
REQ-037 While rstn=0: FSM=IDLE, sdcmd=Z, busy=cmd_valid=resp_done=0, cmd_idx=0, cmd_arg=0, cmd_crcok=0, cmd_endok=0, synchronizers=1.
REQ-038 Reset asserted mid-RX or mid-TX SHALL release sdcmd within the same clk.
REQ-039 The frame in progress at reset SHALL be abandoned; no pulse is emitted.

Verification
REQ-040 Host sends 0x400000000095 (CMD0), then user asserts resp_none -> cmd_valid with idx=0, arg=0, crcok=1, endok=1; sdcmd stays Z; busy falls.
REQ-041 Host sends 0x48000001AA87 (CMD8), user asserts resp_start with idx=8 and arg=0x000001AA -> line carries 0x08000001AA13, with the start bit exactly on the 2nd fall after the end bit; resp_done pulses.
REQ-042 CMD8 frame with CRC byte 0x89 -> cmd_crcok=0, endok=1; the response still proceeds when requested.
REQ-043 Frame with transmission bit 0 -> no cmd_valid; FSM back in IDLE after 48 rises.
REQ-044 rstn pulsed low at TX bit 20 -> sdcmd Z within 1 clk; the next CMD0 is received correctly.
REQ-045 With no user reply for 64 sdclk falls -> IDLE; the next frame is accepted.
